// File: rtl/gcd_sequencer.sv
// Sequencer that feeds operand pairs to an external GCD core over a 4-phase
// req/ack handshake, with a zero-operand bypass and a valid/ready result port.
`timescale 1ns/1ps
module gcd_sequencer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         req,
  output logic [W-1:0] AB,
  input  logic         ack,
  input  logic [W-1:0] C,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_c,
  output logic [15:0]  op_count
);

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    REL_A,
    SEND_B,
    REL_B,
    OUT
  } state_t;

  state_t       state;
  logic [W-1:0] b_hold;

  // Every output is a register loaded with the value it must show in the
  // state being entered, so req and AB always move on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      req       <= 1'b0;
      AB        <= '0;
      b_hold    <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_ready && in_valid) begin
            in_ready <= 1'b0;
            b_hold   <= in_b;
            if ((in_a != '0) && (in_b != '0)) begin
              state <= SEND_A;
              req   <= 1'b1;
              AB    <= in_a;
            end else begin
              state     <= OUT;
              out_valid <= 1'b1;
              out_c     <= in_a | in_b;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        SEND_A: begin
          if (ack) begin
            state <= REL_A;
            req   <= 1'b0;
          end
        end
        REL_A: begin
          if (!ack) begin
            state <= SEND_B;
            req   <= 1'b1;
            AB    <= b_hold;
          end
        end
        SEND_B: begin
          if (ack) begin
            state <= REL_B;
            req   <= 1'b0;
            out_c <= C;
          end
        end
        REL_B: begin
          if (!ack) begin
            state     <= OUT;
            out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            op_count  <= op_count + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          req      <= 1'b0;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a randomly-delayed 4-phase GCD core model plus
// directed and random operand pairs checked against Euclid's algorithm.
`timescale 1ns/1ps
module tb_gcd_sequencer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         req;
  logic [W-1:0] AB;
  logic         ack;
  logic [W-1:0] C;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_c;
  logic [15:0]  op_count;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic         core_ack;
  logic         glitch;
  logic [W-1:0] core_a;
  logic         phase;
  int unsigned  dly;
  logic [W-1:0] ab_log[$];
  logic         req_seen;
  logic         prev_req;
  logic [W-1:0] prev_ab;
  logic [15:0]  exp_count;

  always #5 clk = ~clk;

  assign ack = core_ack | glitch;

  gcd_sequencer #(.W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .req(req), .AB(AB), .ack(ack), .C(C),
    .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
    .op_count(op_count)
  );

  function automatic logic [W-1:0] gcd_ref(input int unsigned a, input int unsigned b);
    int unsigned x = a, y = b, t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core model: answers each req edge after 0..3 cycles, logs operands in order,
  // and only presents a meaningful C while acknowledging the second operand.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_ack <= 1'b0;
      phase    <= 1'b0;
      dly      <= 0;
      C        <= '0;
    end else if (req && !core_ack) begin
      if (dly == 0) begin
        core_ack <= 1'b1;
        ab_log.push_back(AB);
        if (!phase) begin
          core_a <= AB;
          C      <= W'($urandom);
        end else begin
          C <= gcd_ref(core_a, AB);
        end
        phase <= ~phase;
        dly   <= $urandom_range(0, 3);
      end else begin
        dly <= dly - 1;
      end
    end else if (!req && core_ack) begin
      if (dly == 0) begin
        core_ack <= 1'b0;
        C        <= W'($urandom);
        dly      <= $urandom_range(0, 3);
      end else begin
        dly <= dly - 1;
      end
    end
  end

  // AB must hold while req stays high.
  always @(negedge clk) begin
    if (reset && req && prev_req)
      chk("ab_stable_under_req", 64'(AB), 64'(prev_ab));
    if (req) req_seen <= 1'b1;
    prev_req <= req;
    prev_ab  <= AB;
  end

  task automatic transact(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int unsigned t;
    logic bypass;
    logic [W-1:0] exp_c;
    logic [W-1:0] ab0, ab1;
    bypass = (a == '0) || (b == '0);
    exp_c  = gcd_ref(a, b);
    ab_log.delete();
    req_seen = 1'b0;
    in_a = a; in_b = b; in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    if (bypass) begin
      chk("bypass_latency", 64'(out_valid), 64'd1);
    end else begin
      t = 0;
      while (!out_valid && t < 200) begin
        in_valid = 1'($urandom);
        in_a = W'($urandom); in_b = W'($urandom);
        @(negedge clk);
        t++;
      end
      in_valid = 1'b0;
      chk("out_valid_wait", 64'(out_valid), 64'd1);
    end
    chk("out_c", 64'(out_c), 64'(exp_c));
    if (bypass) begin
      chk("req_not_seen", 64'(req_seen), 64'd0);
    end else begin
      ab0 = (ab_log.size() > 0) ? ab_log[0] : 'x;
      ab1 = (ab_log.size() > 1) ? ab_log[1] : 'x;
      chk("ab_sequence", {16'(ab_log.size()), ab0, ab1}, {16'd2, a, b});
    end
    for (int i = 0; i < hold; i++) begin
      glitch = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_c", 64'(out_c), 64'(exp_c));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    glitch = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    chk("op_count", 64'(op_count), 64'(exp_count));
    chk("valid_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int unsigned t;
    logic [W-1:0] ra, rb;
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b0; glitch = 1'b0; exp_count = '0; req_seen = 1'b0;
    prev_req = 1'b0; prev_ab = '0;
    #1;
    chk("rst_req", 64'(req), 64'd0);
    chk("rst_ab", 64'(AB), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_c", 64'(out_c), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("in_ready_after_release", 64'(in_ready), 64'd1);

    transact(16'd12, 16'd21, 0);
    transact(16'd29232, 16'd488, 0);
    transact(16'd49, 16'd98, 0);
    transact(16'd32768, 16'd272, 0);
    transact(16'd91, 16'd63, 0);
    transact(16'd0, 16'd35, 0);
    transact(16'd0, 16'd0, 0);
    transact(16'd91, 16'd63, 10);

    // Abort (49,98) while the second operand is being requested.
    ab_log.delete();
    in_a = 16'd49; in_b = 16'd98; in_valid = 1'b1;
    t = 0;
    while (!(req && AB == 16'd98) && t < 200) begin
      @(negedge clk);
      if (!in_ready) in_valid = 1'b0;
      t++;
    end
    chk("reach_send_b", {63'd0, req && AB == 16'd98}, 64'd1);
    #2 reset = 1'b0;
    #1;
    exp_count = '0;
    chk("abort_req", 64'(req), 64'd0);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_op_count", 64'(op_count), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_resume_req", 64'(req), 64'd0);
    chk("no_resume_valid", 64'(out_valid), 64'd0);
    transact(16'd12, 16'd21, 0);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (n % 3 == 0) begin
        ra = W'($urandom_range(1, 255)) * W'(n + 1);
        rb = W'($urandom_range(1, 255)) * W'(n + 1);
      end
      transact(ra, rb, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
